m72_video_timing: RTL and testbench

M72_VIDEO_TIMING -- requirements
Module: m72_video_timing

---
 rtl/m72_video_timing_if.sv | 29 ++
 rtl/m72_video_timing.sv | 132 +++++++++++++
 tb/tb_m72_video_timing.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m72_video_timing_if.sv
// Bus bundle for the M72 video timing block: CPU I/O write port,
// interrupt acknowledge, and all timing/interrupt outputs.
interface m72_video_timing_if;
  logic [15:0] DIN;
  logic [19:1] A;
  logic [1:0]  BYTE_SEL;
  logic        IOWR;
  logic [1:0]  IRQ_ACK;
  logic        DCLK;
  logic [9:0]  HE;
  logic [8:0]  VE;
  logic        HBLANK;
  logic        VBLANK;
  logic        HSYNC;
  logic        VSYNC;
  logic [1:0]  IRQ;

  // CPU / system side
  modport master (
    output DIN, A, BYTE_SEL, IOWR, IRQ_ACK,
    input  DCLK, HE, VE, HBLANK, VBLANK, HSYNC, VSYNC, IRQ
  );

  // Timing generator side
  modport slave (
    input  DIN, A, BYTE_SEL, IOWR, IRQ_ACK,
    output DCLK, HE, VE, HBLANK, VBLANK, HSYNC, VSYNC, IRQ
  );
endinterface

// File: rtl/m72_video_timing.sv
// M72 video timing generator: 8 MHz dot enable from a 32 MHz clock,
// horizontal/vertical counters, blank/sync windows, and VBLANK/raster
// interrupts with a CPU-programmable raster line.
module m72_video_timing #(
  parameter int HTOTAL     = 512,
  parameter int HVIS_START = 64,
  parameter int HVIS_END   = 448,
  parameter int HS_START   = 472,
  parameter int HS_END     = 504,
  parameter int VTOTAL     = 284,
  parameter int VVIS_END   = 256,
  parameter int VS_START   = 268,
  parameter int VS_END     = 271
) (
  input  logic                CLK_32M,
  input  logic                reset,
  m72_video_timing_if.slave   bus
);

  localparam logic [9:0] H_LAST  = 10'(HTOTAL - 1);
  localparam logic [9:0] H_VS    = 10'(HVIS_START);
  localparam logic [9:0] H_VE    = 10'(HVIS_END);
  localparam logic [9:0] H_SS    = 10'(HS_START);
  localparam logic [9:0] H_SE    = 10'(HS_END);
  localparam logic [8:0] V_LAST  = 9'(VTOTAL - 1);
  localparam logic [8:0] V_VE    = 9'(VVIS_END);
  localparam logic [8:0] V_SS    = 9'(VS_START);
  localparam logic [8:0] V_SE    = 9'(VS_END);
  localparam logic [9:0] V_TOT10 = 10'(VTOTAL);

  logic [1:0] div;
  logic       dclk;
  logic [9:0] he;
  logic [9:0] he_nxt;
  logic [8:0] ve;
  logic [8:0] ve_nxt;
  logic       hblank;
  logic       vblank;
  logic       hsync;
  logic       vsync;
  logic [8:0] raster;
  logic [1:0] irq;
  logic       raster_wr;
  logic       raster_ok;
  logic       set_vbl;
  logic       set_ras;
  logic       unused_bits;

  assign unused_bits = ^{bus.A[19:8], bus.DIN[15:9]};

  // Divide by four; the enable is registered so it lines up with the counter edge
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      div  <= 2'd0;
      dclk <= 1'b0;
    end else begin
      div  <= div + 2'd1;
      dclk <= (div == 2'd3);
    end
  end

  // Next dot/line position; only meaningful on a dot-enable cycle
  always_comb begin
    he_nxt = he;
    ve_nxt = ve;
    if (dclk) begin
      if (he == H_LAST) begin
        he_nxt = 10'd0;
        ve_nxt = (ve == V_LAST) ? 9'd0 : ve + 9'd1;
      end else begin
        he_nxt = he + 10'd1;
      end
    end
  end

  // Counters and decoded windows are registered together so they change on the same edge
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      he     <= 10'd0;
      ve     <= 9'd0;
      hblank <= 1'b1;
      vblank <= 1'b0;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
    end else if (dclk) begin
      he     <= he_nxt;
      ve     <= ve_nxt;
      hblank <= (he_nxt < H_VS) || (he_nxt >= H_VE);
      vblank <= (ve_nxt >= V_VE);
      hsync  <= (he_nxt >= H_SS) && (he_nxt < H_SE);
      vsync  <= (ve_nxt >= V_SS) && (ve_nxt < V_SE);
    end
  end

  // Interrupt set conditions look at the position being stepped to, using the current raster
  always_comb begin
    raster_wr = bus.IOWR && (bus.A[7:1] == 7'b0000011);
    raster_ok = ({1'b0, raster} < V_TOT10);
    set_vbl   = dclk && (he_nxt == 10'd0) && (ve_nxt == V_VE);
    set_ras   = dclk && raster_ok && (he_nxt == H_VS) && (ve_nxt == raster);
  end

  // Raster line register with per-byte-lane writes
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      raster <= 9'h1FF;
    end else if (raster_wr) begin
      if (bus.BYTE_SEL[0]) raster[7:0] <= bus.DIN[7:0];
      if (bus.BYTE_SEL[1]) raster[8]   <= bus.DIN[8];
    end
  end

  // Level interrupts: a set in the same cycle as an acknowledge takes priority
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      irq <= 2'b00;
    end else begin
      irq[0] <= set_vbl | (irq[0] & ~bus.IRQ_ACK[0]);
      irq[1] <= set_ras | (irq[1] & ~bus.IRQ_ACK[1]);
    end
  end

  assign bus.DCLK   = dclk;
  assign bus.HE     = he;
  assign bus.VE     = ve;
  assign bus.HBLANK = hblank;
  assign bus.VBLANK = vblank;
  assign bus.HSYNC  = hsync;
  assign bus.VSYNC  = vsync;
  assign bus.IRQ    = irq;

endmodule

// File: tb/tb_m72_video_timing.sv
// Bench for m72_video_timing with shrunk geometry so whole frames fit in a
// short run. Expected outputs come from a closed-form position model
// (edges since reset -> dot index) plus an interrupt/raster model, queued
// per driven cycle and compared after the edge.
module tb_m72_video_timing;

  localparam int HT  = 32;
  localparam int HVS = 4;
  localparam int HVE = 28;
  localparam int HSS = 29;
  localparam int HSE = 31;
  localparam int VT  = 20;
  localparam int VVE = 16;
  localparam int VSS = 17;
  localparam int VSE = 19;
  localparam int FRAME = HT * VT * 4;

  typedef logic [25:0] ovec_t;
  localparam ovec_t RESET_VEC = {1'b0, 10'd0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};

  logic CLK_32M;
  logic reset;
  m72_video_timing_if bus ();

  m72_video_timing #(
    .HTOTAL(HT), .HVIS_START(HVS), .HVIS_END(HVE), .HS_START(HSS), .HS_END(HSE),
    .VTOTAL(VT), .VVIS_END(VVE), .VS_START(VSS), .VS_END(VSE)
  ) dut (
    .CLK_32M (CLK_32M),
    .reset   (reset),
    .bus     (bus)
  );

  initial CLK_32M = 1'b0;
  always #5 CLK_32M = ~CLK_32M;

  ovec_t      sb[$];
  int         n_edges;
  logic [1:0] m_irq;
  logic [8:0] m_raster;
  int         checks;
  int         errors;

  function automatic int pcnt(int n);
    return (n == 0) ? 0 : (n - 1) / 4;
  endfunction

  function automatic ovec_t expect_vec(int n, logic [1:0] irq);
    int p, he, ve;
    logic dclk, hb, vb, hs, vs;
    p    = pcnt(n);
    he   = p % HT;
    ve   = (p / HT) % VT;
    dclk = (n != 0) && (n % 4 == 0);
    hb   = (he < HVS) || (he >= HVE);
    vb   = (ve >= VVE);
    hs   = (he >= HSS) && (he < HSE);
    vs   = (ve >= VSS) && (ve < VSE);
    return {dclk, 10'(he), 9'(ve), hb, vb, hs, vs, irq};
  endfunction

  function automatic ovec_t obs();
    return {bus.DCLK, bus.HE, bus.VE, bus.HBLANK, bus.VBLANK, bus.HSYNC, bus.VSYNC, bus.IRQ};
  endfunction

  // True when the coming edge steps to the set position of interrupt idx
  function automatic bit will_set(int idx);
    int p0, p1, he, ve;
    p0 = pcnt(n_edges);
    p1 = pcnt(n_edges + 1);
    he = p1 % HT;
    ve = (p1 / HT) % VT;
    if (p1 == p0) return 1'b0;
    if (idx == 0) return (he == 0) && (ve == VVE);
    return (he == HVS) && (ve == int'(m_raster));
  endfunction

  function automatic void model_reset();
    n_edges  = 0;
    m_irq    = 2'b00;
    m_raster = 9'h1FF;
    sb.delete();
  endfunction

  // Advance the model by one edge with the inputs now on the bus, queue the
  // expected post-edge outputs, then let the edge happen.
  task automatic drive_cycle();
    bit s0, s1;
    s0 = will_set(0);
    s1 = will_set(1);
    m_irq[0] = s0 ? 1'b1 : (bus.IRQ_ACK[0] ? 1'b0 : m_irq[0]);
    m_irq[1] = s1 ? 1'b1 : (bus.IRQ_ACK[1] ? 1'b0 : m_irq[1]);
    if (bus.IOWR && bus.A[7:1] == 7'b0000011) begin
      if (bus.BYTE_SEL[0]) m_raster[7:0] = bus.DIN[7:0];
      if (bus.BYTE_SEL[1]) m_raster[8]   = bus.DIN[8];
    end
    n_edges++;
    sb.push_back(expect_vec(n_edges, m_irq));
    @(posedge CLK_32M);
    #1;
  endtask

  task automatic set_write(input logic [6:0] a71, input logic [15:0] din, input logic [1:0] be);
    bus.A        = 19'h0;
    bus.A[7:1]   = a71;
    bus.DIN      = din;
    bus.BYTE_SEL = be;
    bus.IOWR     = 1'b1;
  endtask

  task automatic test_reset();
    ovec_t got;
    reset = 1'b1;
    #2;
    got = obs();
    checks++;
    if (got !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_async: got %h want %h", got, RESET_VEC);
    end
    repeat (3) @(posedge CLK_32M);
    #1;
    got = obs();
    checks++;
    if (got !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_held: got %h want %h", got, RESET_VEC);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_dclk_counters();
    ovec_t e, got;
    for (int i = 1; i <= HT * 4 * 2 + 8; i++) begin
      drive_cycle();
      e   = sb.pop_front();
      got = obs();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL dclk_seq edge %0d: got %h want %h", i, got, e);
      end
      if (i == 3 || i == 4 || i == 8) begin
        checks++;
        if (bus.DCLK !== (i != 3)) begin
          errors++;
          $display("FAIL dclk_edge %0d: got %b want %b", i, bus.DCLK, (i != 3));
        end
      end
      if (i == 5) begin
        checks++;
        if (bus.HE !== 10'd1) begin
          errors++;
          $display("FAIL he_first_step: got %0d want 1", bus.HE);
        end
      end
      if (i == HT * 4 + 1) begin
        checks++;
        if (bus.HE !== 10'd0 || bus.VE !== 9'd1) begin
          errors++;
          $display("FAIL line_wrap: got HE=%0d VE=%0d want HE=0 VE=1", bus.HE, bus.VE);
        end
      end
    end
  endtask

  task automatic test_frame();
    ovec_t e, got;
    bit seen_vbl;
    seen_vbl = 1'b0;
    for (int i = 0; i < FRAME + 16; i++) begin
      drive_cycle();
      e   = sb.pop_front();
      got = obs();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL frame cyc %0d: got %h want %h", i, got, e);
      end
      if (!seen_vbl && bus.VBLANK === 1'b1) begin
        seen_vbl = 1'b1;
        checks++;
        if (bus.VE !== 9'(VVE) || bus.HE !== 10'd0 || bus.IRQ[0] !== 1'b1) begin
          errors++;
          $display("FAIL vblank_rise: got VE=%0d HE=%0d IRQ0=%b want VE=%0d HE=0 IRQ0=1",
                   bus.VE, bus.HE, bus.IRQ[0], VVE);
        end
      end
    end
    checks++;
    if (!seen_vbl) begin
      errors++;
      $display("FAIL vblank_seen: got 0 want 1");
    end
  endtask

  task automatic test_raster();
    ovec_t e, got;
    bit seen;
    for (int phase = 0; phase < 3; phase++) begin
      case (phase)
        0:       set_write(7'b0000011, 16'h0164, 2'b11);
        1:       set_write(7'b0000011, 16'h000A, 2'b01);
        default: set_write(7'b0000011, 16'h0000, 2'b10);
      endcase
      drive_cycle();
      bus.IOWR = 1'b0;
      e   = sb.pop_front();
      got = obs();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL raster_wr phase %0d: got %h want %h", phase, got, e);
      end
      seen = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
        drive_cycle();
        e   = sb.pop_front();
        got = obs();
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL raster phase %0d cyc %0d: got %h want %h", phase, i, got, e);
        end
        if (!seen && bus.IRQ[1] === 1'b1) begin
          seen = 1'b1;
          checks++;
          if (phase != 2 || bus.VE !== 9'd10 || bus.HE !== 10'(HVS)) begin
            errors++;
            $display("FAIL raster_irq phase %0d: got VE=%0d HE=%0d want no irq or VE=10 HE=%0d",
                     phase, bus.VE, bus.HE, HVS);
          end
        end
      end
      checks++;
      if (seen !== (phase == 2)) begin
        errors++;
        $display("FAIL raster_fired phase %0d: got %b want %b", phase, seen, (phase == 2));
      end
    end
  endtask

  task automatic test_irq_ack();
    ovec_t e, got;
    logic irq0_before;
    bit guard, hit;
    irq0_before = bus.IRQ[0];
    guard = will_set(1);
    bus.IRQ_ACK = 2'b10;
    drive_cycle();
    bus.IRQ_ACK = 2'b00;
    e   = sb.pop_front();
    got = obs();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL ack1: got %h want %h", got, e);
    end
    if (!guard) begin
      checks++;
      if (bus.IRQ[1] !== 1'b0 || bus.IRQ[0] !== irq0_before) begin
        errors++;
        $display("FAIL ack1_levels: got IRQ=%b want IRQ1=0 IRQ0=%b", bus.IRQ, irq0_before);
      end
    end
    bus.IRQ_ACK = 2'b01;
    drive_cycle();
    bus.IRQ_ACK = 2'b00;
    e   = sb.pop_front();
    got = obs();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL ack0: got %h want %h", got, e);
    end
    hit = 1'b0;
    for (int i = 0; i < FRAME + 8 && !hit; i++) begin
      if (will_set(0)) begin
        hit = 1'b1;
        bus.IRQ_ACK = 2'b01;
      end
      drive_cycle();
      bus.IRQ_ACK = 2'b00;
      e   = sb.pop_front();
      got = obs();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL ack_race cyc %0d: got %h want %h", i, got, e);
      end
      if (hit) begin
        checks++;
        if (bus.IRQ[0] !== 1'b1) begin
          errors++;
          $display("FAIL set_beats_ack: got IRQ0=%b want 1", bus.IRQ[0]);
        end
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL ack_race_timeout: got no set cycle want one within a frame");
    end
  endtask

  task automatic test_bad_addr();
    ovec_t e, got;
    bit seen;
    bus.IRQ_ACK = 2'b11;
    drive_cycle();
    bus.IRQ_ACK = 2'b00;
    void'(sb.pop_front());
    set_write(7'b0000100, 16'h0003, 2'b11);
    drive_cycle();
    bus.IOWR = 1'b0;
    void'(sb.pop_front());
    seen = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      drive_cycle();
      e   = sb.pop_front();
      got = obs();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL bad_addr cyc %0d: got %h want %h", i, got, e);
      end
      if (!seen && bus.IRQ[1] === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (bus.VE !== 9'd10 || bus.HE !== 10'(HVS)) begin
          errors++;
          $display("FAIL bad_addr_line: got VE=%0d HE=%0d want VE=10 HE=%0d", bus.VE, bus.HE, HVS);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bad_addr_fired: got 0 want 1");
    end
  endtask

  task automatic test_reset_midline();
    ovec_t e, got;
    bit found;
    found = 1'b0;
    for (int i = 0; i < FRAME + 8 && !found; i++) begin
      drive_cycle();
      void'(sb.pop_front());
      if (bus.DCLK === 1'b0 && (pcnt(n_edges) % HT) == 20 && ((pcnt(n_edges) / HT) % VT) == 5)
        found = 1'b1;
    end
    checks++;
    if (!found || bus.HE !== 10'd20 || bus.VE !== 9'd5) begin
      errors++;
      $display("FAIL midline_pos: got HE=%0d VE=%0d want HE=20 VE=5", bus.HE, bus.VE);
    end
    #1;
    reset = 1'b1;
    #1;
    got = obs();
    checks++;
    if (got !== RESET_VEC) begin
      errors++;
      $display("FAIL midline_reset: got %h want %h", got, RESET_VEC);
    end
    @(posedge CLK_32M);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 1; i <= 12; i++) begin
      drive_cycle();
      e   = sb.pop_front();
      got = obs();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL restart edge %0d: got %h want %h", i, got, e);
      end
      if (i == 3 || i == 4) begin
        checks++;
        if (bus.DCLK !== (i == 4)) begin
          errors++;
          $display("FAIL restart_dclk edge %0d: got %b want %b", i, bus.DCLK, (i == 4));
        end
      end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.DIN      = 16'h0;
    bus.A        = 19'h0;
    bus.BYTE_SEL = 2'b00;
    bus.IOWR     = 1'b0;
    bus.IRQ_ACK  = 2'b00;
    model_reset();
    test_reset();
    test_dclk_counters();
    test_frame();
    test_raster();
    test_irq_ack();
    test_bad_addr();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
